// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: FSM states, MEM/WB payload, counter width.
package mem_stage_pkg;

  localparam int unsigned CNT_W         = 4;
  localparam int unsigned MEM_DATA_W    = 16;
  localparam int unsigned MEM_REG_IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // MEM/WB latch payload; widen the package widths above to retarget the datapath
  typedef struct packed {
    logic                     reg_write;
    logic                     ret_future;
    logic                     mem_to_reg;
    logic [MEM_REG_IDX_W-1:0] rd;
    logic [MEM_DATA_W-1:0]    alu_result;
    logic [MEM_DATA_W-1:0]    read_data;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_unit_if.sv
// EX -> MEM request / MEM -> WB result bundle for the MEM stage.
interface mem_stage_unit_if #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned REG_IDX_W = 4
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic                 mem_read;
  logic                 mem_write;
  logic                 reg_write_in;
  logic                 ret_future_in;
  logic [REG_IDX_W-1:0] reg_rd_in;
  logic [DATA_W-1:0]    alu_result_in;
  logic [DATA_W-1:0]    mem_write_data;
  logic                 stall;
  logic                 out_valid;
  logic                 reg_write_out;
  logic                 ret_future_out;
  logic                 mem_to_reg_out;
  logic [REG_IDX_W-1:0] reg_rd_out;
  logic [DATA_W-1:0]    alu_result_out;
  logic [DATA_W-1:0]    mem_read_data;

  modport master (
    output in_valid, flush, mem_read, mem_write, reg_write_in, ret_future_in,
           reg_rd_in, alu_result_in, mem_write_data,
    input  in_ready, stall, out_valid, reg_write_out, ret_future_out,
           mem_to_reg_out, reg_rd_out, alu_result_out, mem_read_data
  );

  modport slave (
    input  in_valid, flush, mem_read, mem_write, reg_write_in, ret_future_in,
           reg_rd_in, alu_result_in, mem_write_data,
    output in_ready, stall, out_valid, reg_write_out, ret_future_out,
           mem_to_reg_out, reg_rd_out, alu_result_out, mem_read_data
  );

endinterface

// File: rtl/data_mem_array.sv
// Single-port data memory: combinational read, synchronous write, contents never reset.
module data_mem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: one request per handshake, optional load/store with MEM_LAT-cycle
// access, flush squash, and a registered MEM/WB latch qualified by out_valid.
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W    = MEM_DATA_W,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned REG_IDX_W = MEM_REG_IDX_W,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = (MEM_LAT > 1) ? CNT_W'(MEM_LAT - 2) : '0;

  if (MEM_LAT < 1 || MEM_LAT > 16) begin : g_bad_lat
    $error("mem_stage_unit: MEM_LAT must be within 1..16");
  end
  if (DATA_W != MEM_DATA_W || REG_IDX_W != MEM_REG_IDX_W || ADDR_W > DATA_W) begin : g_bad_w
    $error("mem_stage_unit: widths must match mem_stage_pkg and ADDR_W <= DATA_W");
  end

  typedef struct packed {
    logic                 is_wr;
    logic                 is_rd;
    logic                 reg_write;
    logic                 ret_future;
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    alu;
    logic [DATA_W-1:0]    wdata;
  } req_t;

  mem_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  req_t              req_q;
  req_t              req_in;
  req_t              op;
  mem_wb_t           wb_q;
  mem_wb_t           wb_d;
  logic              out_valid_q;
  logic              accept;
  logic              fast;
  logic              done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign bus.in_ready = (state_q == IDLE) & ~rst & ~bus.flush;

  // Completion path: fast ops use the live request, BUSY completion uses the latched one
  always_comb begin
    req_in            = '0;
    req_in.is_wr      = bus.mem_write;
    req_in.is_rd      = bus.mem_read & ~bus.mem_write;
    req_in.reg_write  = bus.reg_write_in;
    req_in.ret_future = bus.ret_future_in;
    req_in.rd         = bus.reg_rd_in;
    req_in.alu        = bus.alu_result_in;
    req_in.wdata      = bus.mem_write_data;

    accept = bus.in_valid & bus.in_ready;
    fast   = accept & ((~req_in.is_wr & ~req_in.is_rd) | (MEM_LAT == 1));
    done   = (state_q == BUSY) & ~bus.flush & (cnt_q == '0);
    op     = fast ? req_in : req_q;

    mem_addr = op.alu[ADDR_W-1:0];
    mem_we   = ~rst & op.is_wr & (fast | done);

    wb_d            = '0;
    wb_d.reg_write  = op.reg_write;
    wb_d.ret_future = op.ret_future;
    wb_d.mem_to_reg = op.is_rd;
    wb_d.rd         = op.rd;
    wb_d.alu_result = op.alu;
    wb_d.read_data  = op.is_rd ? mem_rdata : '0;
  end

  data_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (op.wdata),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      wb_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            req_q <= req_in;
            if (fast) begin
              wb_q        <= wb_d;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          // flush aborts the access before it can commit
          if (bus.flush) begin
            state_q <= IDLE;
          end else if (done) begin
            wb_q        <= wb_d;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall          = (state_q == BUSY);
  assign bus.out_valid      = out_valid_q;
  assign bus.reg_write_out  = wb_q.reg_write & out_valid_q;
  assign bus.ret_future_out = wb_q.ret_future;
  assign bus.mem_to_reg_out = wb_q.mem_to_reg;
  assign bus.reg_rd_out     = wb_q.rd;
  assign bus.alu_result_out = wb_q.alu_result;
  assign bus.mem_read_data  = wb_q.read_data;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed vector bench for mem_stage_unit at MEM_LAT = 1, 3 and 4 sharing one stimulus bus.
module tb_mem_stage_unit;

  localparam int NOP = 0, LD = 1, ST = 2, LDST = 3, ALU = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, mem_read, mem_write, reg_write_in, ret_future_in;
  logic [3:0]  reg_rd_in;
  logic [15:0] alu_result_in, mem_write_data;

  always #5 clk = ~clk;

  mem_stage_unit_if #(.DATA_W(16), .REG_IDX_W(4)) if1 ();
  mem_stage_unit_if #(.DATA_W(16), .REG_IDX_W(4)) if3 ();
  mem_stage_unit_if #(.DATA_W(16), .REG_IDX_W(4)) if4 ();

  assign if1.in_valid = in_valid;       assign if3.in_valid = in_valid;       assign if4.in_valid = in_valid;
  assign if1.flush = flush;             assign if3.flush = flush;             assign if4.flush = flush;
  assign if1.mem_read = mem_read;       assign if3.mem_read = mem_read;       assign if4.mem_read = mem_read;
  assign if1.mem_write = mem_write;     assign if3.mem_write = mem_write;     assign if4.mem_write = mem_write;
  assign if1.reg_write_in = reg_write_in;   assign if3.reg_write_in = reg_write_in;   assign if4.reg_write_in = reg_write_in;
  assign if1.ret_future_in = ret_future_in; assign if3.ret_future_in = ret_future_in; assign if4.ret_future_in = ret_future_in;
  assign if1.reg_rd_in = reg_rd_in;     assign if3.reg_rd_in = reg_rd_in;     assign if4.reg_rd_in = reg_rd_in;
  assign if1.alu_result_in = alu_result_in; assign if3.alu_result_in = alu_result_in; assign if4.alu_result_in = alu_result_in;
  assign if1.mem_write_data = mem_write_data; assign if3.mem_write_data = mem_write_data; assign if4.mem_write_data = mem_write_data;

  mem_stage_unit #(.DATA_W(16), .ADDR_W(10), .REG_IDX_W(4), .MEM_LAT(1)) u_lat1 (.clk(clk), .rst(rst), .bus(if1));
  mem_stage_unit #(.DATA_W(16), .ADDR_W(10), .REG_IDX_W(4), .MEM_LAT(3)) u_lat3 (.clk(clk), .rst(rst), .bus(if3));
  mem_stage_unit #(.DATA_W(16), .ADDR_W(10), .REG_IDX_W(4), .MEM_LAT(4)) u_lat4 (.clk(clk), .rst(rst), .bus(if4));

  typedef struct packed {
    logic        in_ready, stall, out_valid, reg_write_out, ret_future_out, mem_to_reg_out;
    logic [3:0]  reg_rd_out;
    logic [15:0] alu_result_out, mem_read_data;
  } obs_t;

  obs_t obs1, obs3, obs4;
  assign obs1 = {if1.in_ready, if1.stall, if1.out_valid, if1.reg_write_out, if1.ret_future_out,
                 if1.mem_to_reg_out, if1.reg_rd_out, if1.alu_result_out, if1.mem_read_data};
  assign obs3 = {if3.in_ready, if3.stall, if3.out_valid, if3.reg_write_out, if3.ret_future_out,
                 if3.mem_to_reg_out, if3.reg_rd_out, if3.alu_result_out, if3.mem_read_data};
  assign obs4 = {if4.in_ready, if4.stall, if4.out_valid, if4.reg_write_out, if4.ret_future_out,
                 if4.mem_to_reg_out, if4.reg_rd_out, if4.alu_result_out, if4.mem_read_data};

  typedef struct {
    int          sel;
    bit          rst, fl, iv, mr, mw, rw, rf;
    logic [3:0]  rd;
    logic [15:0] alu, wd;
    bit          ck_c, ck_d;
    bit          e_ir, e_st, e_ov, e_rwo, e_rf, e_m2r;
    logic [3:0]  e_rd;
    logic [15:0] e_alu, e_rdata;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(int sel, bit r, bit f, int kind, int rd, int alu, int wd, bit rf);
    vec_t v = '{default: 0};
    v.sel = sel; v.rst = r; v.fl = f; v.rf = rf;
    v.iv  = (kind != NOP);
    v.mr  = (kind == LD) || (kind == LDST);
    v.mw  = (kind == ST) || (kind == LDST);
    v.rw  = (kind == LD) || (kind == ALU);
    v.rd  = 4'(rd); v.alu = 16'(alu); v.wd = 16'(wd);
    return v;
  endfunction

  function automatic vec_t c(vec_t v, bit ir, bit st, bit ov, bit rwo);
    v.ck_c = 1'b1; v.e_ir = ir; v.e_st = st; v.e_ov = ov; v.e_rwo = rwo;
    return v;
  endfunction

  function automatic vec_t d(vec_t v, bit rf, bit m2r, int rd, int alu, int rdata);
    v.ck_d = 1'b1; v.e_rf = rf; v.e_m2r = m2r;
    v.e_rd = 4'(rd); v.e_alu = 16'(alu); v.e_rdata = 16'(rdata);
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [vec %0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; flush = v.fl; in_valid = v.iv; mem_read = v.mr; mem_write = v.mw;
    reg_write_in = v.rw; ret_future_in = v.rf; reg_rd_in = v.rd;
    alu_result_in = v.alu; mem_write_data = v.wd;
  endtask

  task automatic apply(input int idx, input vec_t v);
    obs_t o;
    @(negedge clk);
    drive(v);
    #1;
    o = (v.sel == 1) ? obs1 : (v.sel == 3) ? obs3 : obs4;
    if (v.ck_c) begin
      check("in_ready",      idx, 16'(o.in_ready),      16'(v.e_ir));
      check("stall",         idx, 16'(o.stall),         16'(v.e_st));
      check("out_valid",     idx, 16'(o.out_valid),     16'(v.e_ov));
      check("reg_write_out", idx, 16'(o.reg_write_out), 16'(v.e_rwo));
    end
    if (v.ck_d) begin
      check("ret_future_out", idx, 16'(o.ret_future_out), 16'(v.e_rf));
      check("mem_to_reg_out", idx, 16'(o.mem_to_reg_out), 16'(v.e_m2r));
      check("reg_rd_out",     idx, 16'(o.reg_rd_out),     16'(v.e_rd));
      check("alu_result_out", idx, o.alu_result_out,      v.e_alu);
      check("mem_read_data",  idx, o.mem_read_data,       v.e_rdata);
    end
  endtask

  initial begin
    int lat;
    drive(mk(1, 1, 0, NOP, 0, 0, 0, 0));
    repeat (2) @(posedge clk);

    // MEM_LAT=1: store/load, upper address bits, read+write, flush in IDLE
    vq.push_back(d(c(mk(1,1,0,NOP,0,0,0,0),0,0,0,0),0,0,0,0,0));
    vq.push_back(c(mk(1,0,0,ST,0,'h0005,'hBEEF,0),1,0,0,0));
    vq.push_back(d(c(mk(1,0,0,LD,3,'h0005,0,0),1,0,1,0),0,0,0,'h0005,0));
    vq.push_back(d(c(mk(1,0,0,NOP,0,0,0,0),1,0,1,1),0,1,3,'h0005,'hBEEF));
    vq.push_back(d(c(mk(1,0,0,NOP,0,0,0,0),1,0,0,0),0,1,3,'h0005,'hBEEF));
    vq.push_back(c(mk(1,0,0,LD,4,'hFC05,0,1),1,0,0,0));
    vq.push_back(d(c(mk(1,0,0,NOP,0,0,0,0),1,0,1,1),1,1,4,'hFC05,'hBEEF));
    vq.push_back(c(mk(1,0,0,LDST,6,'h0002,'h5A5A,0),1,0,0,0));
    vq.push_back(d(c(mk(1,0,0,LD,7,'h0002,0,0),1,0,1,0),0,0,6,'h0002,0));
    vq.push_back(d(c(mk(1,0,0,NOP,0,0,0,0),1,0,1,1),0,1,7,'h0002,'h5A5A));
    vq.push_back(c(mk(1,0,1,ALU,8,'h0777,0,0),0,0,0,0));
    vq.push_back(d(c(mk(1,0,0,NOP,0,0,0,0),1,0,0,0),0,1,7,'h0002,'h5A5A));

    // MEM_LAT=4: ALU op, store, load, stalled ALU op, reset mid-BUSY, dropped write
    vq.push_back(mk(4,1,0,NOP,0,0,0,0));
    vq.push_back(d(c(mk(4,1,0,NOP,0,0,0,0),0,0,0,0),0,0,0,0,0));
    vq.push_back(c(mk(4,0,0,ALU,5,'h1234,0,0),1,0,0,0));
    vq.push_back(d(c(mk(4,0,0,ST,0,'h0009,'h4321,0),1,0,1,1),0,0,5,'h1234,0));
    vq.push_back(d(c(mk(4,0,0,LD,2,'h0009,0,0),0,1,0,0),0,0,5,'h1234,0));
    vq.push_back(c(mk(4,0,0,LD,2,'h0009,0,0),0,1,0,0));
    vq.push_back(c(mk(4,0,0,LD,2,'h0009,0,0),0,1,0,0));
    vq.push_back(d(c(mk(4,0,0,LD,2,'h0009,0,0),1,0,1,0),0,0,0,'h0009,0));
    for (int k = 0; k < 3; k++) vq.push_back(c(mk(4,0,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(d(c(mk(4,0,0,NOP,0,0,0,0),1,0,1,1),0,1,2,'h0009,'h4321));
    vq.push_back(c(mk(4,0,0,LD,1,'h0009,0,0),1,0,0,0));
    for (int k = 0; k < 3; k++) vq.push_back(c(mk(4,0,0,ALU,10,'h00AB,0,0),0,1,0,0));
    vq.push_back(d(c(mk(4,0,0,ALU,10,'h00AB,0,0),1,0,1,1),0,1,1,'h0009,'h4321));
    vq.push_back(d(c(mk(4,0,0,NOP,0,0,0,0),1,0,1,1),0,0,10,'h00AB,0));
    vq.push_back(c(mk(4,0,0,LD,1,'h0009,0,0),1,0,0,0));
    vq.push_back(c(mk(4,0,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(c(mk(4,1,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(d(c(mk(4,1,0,NOP,0,0,0,0),0,0,0,0),0,0,0,0,0));
    vq.push_back(c(mk(4,0,0,NOP,0,0,0,0),1,0,0,0));
    vq.push_back(c(mk(4,0,0,ST,0,'h0009,'hDEAD,0),1,0,0,0));
    vq.push_back(c(mk(4,0,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(c(mk(4,0,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(c(mk(4,1,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(d(c(mk(4,0,0,NOP,0,0,0,0),1,0,0,0),0,0,0,0,0));
    vq.push_back(c(mk(4,0,0,LD,1,'h0009,0,0),1,0,0,0));
    for (int k = 0; k < 3; k++) vq.push_back(c(mk(4,0,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(d(c(mk(4,0,0,NOP,0,0,0,0),1,0,1,1),0,1,1,'h0009,'h4321));

    // MEM_LAT=3: flush one cycle after accept and in the completion cycle
    vq.push_back(mk(3,1,0,NOP,0,0,0,0));
    vq.push_back(c(mk(3,1,0,NOP,0,0,0,0),0,0,0,0));
    vq.push_back(c(mk(3,0,0,ST,0,'h0007,'h1111,0),1,0,0,0));
    vq.push_back(c(mk(3,0,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(c(mk(3,0,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(d(c(mk(3,0,0,NOP,0,0,0,0),1,0,1,0),0,0,0,'h0007,0));
    vq.push_back(c(mk(3,0,0,ST,0,'h0007,'h00AA,0),1,0,0,0));
    vq.push_back(c(mk(3,0,1,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(d(c(mk(3,0,0,NOP,0,0,0,0),1,0,0,0),0,0,0,'h0007,0));
    vq.push_back(c(mk(3,0,0,NOP,0,0,0,0),1,0,0,0));
    vq.push_back(c(mk(3,0,0,LD,9,'h0007,0,0),1,0,0,0));
    vq.push_back(c(mk(3,0,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(c(mk(3,0,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(d(c(mk(3,0,0,NOP,0,0,0,0),1,0,1,1),0,1,9,'h0007,'h1111));
    vq.push_back(c(mk(3,0,0,ST,0,'h0007,'h00BB,0),1,0,0,0));
    vq.push_back(c(mk(3,0,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(c(mk(3,0,1,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(c(mk(3,0,0,NOP,0,0,0,0),1,0,0,0));
    vq.push_back(c(mk(3,0,0,LD,9,'h0007,0,0),1,0,0,0));
    vq.push_back(c(mk(3,0,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(c(mk(3,0,0,NOP,0,0,0,0),0,1,0,0));
    vq.push_back(d(c(mk(3,0,0,NOP,0,0,0,0),1,0,1,1),0,1,9,'h0007,'h1111));

    foreach (vq[i]) apply(i, vq[i]);

    // Hand sequence: measure MEM_LAT=4 load latency with a bounded wait
    @(negedge clk); drive(mk(4,1,0,NOP,0,0,0,0));
    @(negedge clk); drive(mk(4,0,0,LD,12,'h0009,0,0));
    @(negedge clk); drive(mk(4,0,0,NOP,0,0,0,0));
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (if4.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("lat4_latency",   -1, 16'(lat), 16'd4);
    check("lat4_read_data", -1, if4.mem_read_data, 16'h4321);
    check("lat4_reg_rd",    -1, 16'(if4.reg_rd_out), 16'd12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
